fifo_ctrl: RTL
==============

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of stored words.
REQ-002 SHALL have parameter ADDR_W, default 3, RAM address width (depth 2**ADDR_W = 8).
REQ-003 SHALL have parameter AF_THR, default 6, almost-full threshold (entries).
REQ-004 SHALL have parameter AE_THR, default 2, almost-empty threshold (entries).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have ports: reset_L  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: push  in  1  write request, held until push_ack.
REQ-008 SHALL have ports: data_in  in  DATA_W  write data, valid with push.
REQ-009 SHALL have ports: pop  in  1  read request, held until pop_ack.
REQ-010 SHALL have ports: push_ack, pop_ack  out  1 each  combinational grant this cycle.
REQ-011 SHALL have ports: ram_we, ram_re  out  1 each  RAM write/read enable.
REQ-012 SHALL have ports: ram_addr_w, ram_addr_r  out  ADDR_W each  RAM write/read address.
REQ-013 SHALL have ports: ram_data  out  DATA_W  RAM write data (= data_in).
REQ-014 SHALL have ports: rd_valid  out  1  RAM read data valid this cycle.
REQ-015 SHALL have ports: count  out  ADDR_W+1  occupancy; full, empty, almost_full, almost_empty  out  1 each.
REQ-016 SHALL have ports: overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-017 SHALL keep registered wr_ptr, rd_ptr (ADDR_W bits, wrap 7->0) and count (0..8).
REQ-018 SHALL treat push eligible when push && !full; pop eligible when pop && !empty.
REQ-019 SHALL grant at most one of push/pop per cycle (RAM write has priority over read internally, so both cannot be issued together).
REQ-020 SHALL grant the sole eligible request when only one is eligible.
REQ-021 SHALL, when both eligible, grant round-robin: opposite of registered last_grant; last_grant updates on every grant.
REQ-022 SHALL drive ram_we=push_ack, ram_addr_w=wr_ptr, ram_re=pop_ack, ram_addr_r=rd_ptr, all combinational.
REQ-023 SHALL on push_ack edge: wr_ptr+1, count+1; on pop_ack edge: rd_ptr+1, count-1.
REQ-024 SHALL assert rd_valid exactly one cycle after each pop_ack (registered RAM output latency 1).
REQ-025 SHALL derive flags from registered count: empty=(count==0), full=(count==8), almost_full=(count>=AF_THR), almost_empty=(count<=AE_THR).
REQ-026 SHALL pulse overflow one cycle after a cycle with push && full; no pointer/count change.
REQ-027 SHALL pulse underflow one cycle after a cycle with pop && empty; no pointer/count change.
REQ-028 SHALL, when full and both requested, grant pop only, without overflow if push later succeeds (overflow still pulses for the full cycle per REQ-026).
REQ-029 SHALL, when empty and both requested, grant push only; underflow pulses per REQ-027.
REQ-030 SHALL never let count exceed 8 or go below 0.

Reset
REQ-031 SHALL on reset_L=0 asynchronously clear wr_ptr, rd_ptr, count, rd_valid, overflow, underflow; set last_grant=pop (first conflict grants push).
REQ-032 SHALL give reset outputs: empty=1, almost_empty=1, full=0, almost_full=0, count=0, acks/enables 0 while reset_L=0.
REQ-033 SHALL, on reset mid-operation, discard in-flight rd_valid and all stored entries (RAM contents not cleared, but unreachable).

Verification
REQ-034 Reset, then 8 pushes 0x3A0..0x3A7 -> count 1..8, almost_full at count 6, full at 8, ram_addr_w 0..7.
REQ-035 Full, push held 1 cycle -> push_ack=0, overflow pulse next cycle, count stays 8.
REQ-036 Full, 8 pops -> ram_addr_r 0..7, rd_valid one cycle after each pop_ack, data 0x3A0..0x3A7 in order, empty at end.
REQ-037 Count 4, push and pop held 4 cycles -> grants push,pop,push,pop; count 5,4,5,4.
REQ-038 Empty, pop held -> underflow pulse, no rd_valid; empty with push+pop -> push granted, count 1.
REQ-039 Count 5, reset_L low mid-cycle -> immediate count 0, empty 1, rd_valid 0; next push writes address 0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external single-port-per-direction RAM with registered read data.
// Arbitrates push/pop one-per-cycle (round-robin on conflict) and tracks occupancy and status flags.
module fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int AF_THR = 6,
  parameter int AE_THR = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr_w,
  output logic [ADDR_W-1:0] ram_addr_r,
  output logic [DATA_W-1:0] ram_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic {
    GRANT_PUSH = 1'b0,
    GRANT_POP  = 1'b1
  } grant_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL   = AF_THR[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL   = AE_THR[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  grant_e            last_grant;
  logic              push_ok;
  logic              pop_ok;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // Only one RAM port is driven per cycle; on conflict alternate against the previous winner.
  always_comb begin
    push_ack = 1'b0;
    pop_ack  = 1'b0;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (reset_L) begin
      if (push_ok && pop_ok) begin
        if (last_grant == GRANT_POP) push_ack = 1'b1;
        else                         pop_ack  = 1'b1;
      end else begin
        push_ack = push_ok;
        pop_ack  = pop_ok;
      end
    end
  end

  assign ram_we     = push_ack;
  assign ram_re     = pop_ack;
  assign ram_addr_w = wr_ptr;
  assign ram_addr_r = rd_ptr;
  assign ram_data   = data_in;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      last_grant <= GRANT_POP;
    end else begin
      rd_valid  <= pop_ack;
      overflow  <= push && full;
      underflow <= pop && empty;
      if (push_ack) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        count      <= count + (ADDR_W + 1)'(1);
        last_grant <= GRANT_PUSH;
      end else if (pop_ack) begin
        rd_ptr     <= rd_ptr + ADDR_W'(1);
        count      <= count - (ADDR_W + 1)'(1);
        last_grant <= GRANT_POP;
      end
    end
  end

endmodule
